// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with PC, one-entry hold buffer and IF/ID register.
// Ports: clk/rst, hazard controls, branch redirect, imem handshake, IF/ID outputs, stall_count.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             IFID_write,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IFID_pc4,
  output logic [31:0]      IFID_instr,
  output logic             IFID_valid,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] hold;
  logic        fire;
  logic        ld_mem;
  logic        ld_hold;
  logic        cap;
  logic        bubble;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign pc4  = pc + 32'd4;
  assign fire = (state == S_FETCH) && imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_START;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_START: state_nx = S_FETCH;
      S_FETCH: begin
        if (!branch_taken && fire && !IFID_write)
          state_nx = S_HOLD;
        else
          state_nx = S_FETCH;
      end
      S_HOLD: begin
        if (branch_taken || IFID_write)
          state_nx = S_FETCH;
      end
      default: state_nx = S_START;
    endcase
  end

  // A fetch accepted with IFID_write=1 but PCWrite=0 is dropped as a
  // bubble so the same PC is fetched again rather than duplicated.
  always_comb begin
    imem_req  = (state == S_FETCH);
    imem_addr = pc;
    ld_mem    = 1'b0;
    ld_hold   = 1'b0;
    cap       = 1'b0;
    bubble    = 1'b0;
    if (branch_taken) begin
      bubble = 1'b1;
    end else begin
      case (state)
        S_FETCH: begin
          ld_mem = fire && IFID_write && PCWrite;
          cap    = fire && !IFID_write;
          bubble = IFID_write && !(fire && PCWrite);
        end
        S_HOLD:  ld_hold = IFID_write;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      hold       <= NOP_INSTR;
      IFID_pc4   <= '0;
      IFID_instr <= NOP_INSTR;
      IFID_valid <= 1'b0;
    end else begin
      if (branch_taken)          pc <= branch_target;
      else if (ld_mem || ld_hold) pc <= pc4;

      if (branch_taken) hold <= NOP_INSTR;
      else if (cap)     hold <= imem_rdata;

      if (ld_mem) begin
        IFID_pc4   <= pc4;
        IFID_instr <= imem_rdata;
        IFID_valid <= 1'b1;
      end else if (ld_hold) begin
        IFID_pc4   <= pc4;
        IFID_instr <= hold;
        IFID_valid <= 1'b1;
      end else if (bubble) begin
        IFID_pc4   <= '0;
        IFID_instr <= NOP_INSTR;
        IFID_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (!IFID_write && !branch_taken && stall_count != CNT_MAX)
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard testbench for if_fetch_stage.
// Drives fetch, stall, hold, branch, wrap, saturation and async reset cases.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, IFID_write, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_req, imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_pc4, IFID_instr;
  logic        IFID_valid;
  logic [3:0]  stall_count;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  ifid_t q[$];
  ifid_t e;
  int    n_cmp = 0;
  int    n_err = 0;
  logic [3:0] m_stall;

  if_fetch_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFID_write(IFID_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .IFID_pc4(IFID_pc4), .IFID_instr(IFID_instr),
    .IFID_valid(IFID_valid), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) m_stall <= '0;
    else if (!IFID_write && !branch_taken && m_stall != 4'hF)
      m_stall <= m_stall + 4'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; PCWrite = 1'b1; IFID_write = 1'b1; branch_taken = 1'b0;
    branch_target = '0; imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
    #2;
    n_cmp++;
    if ({imem_addr, imem_req, IFID_pc4, IFID_instr, IFID_valid, stall_count}
        !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0}) begin
      n_err++;
      $display("FAIL reset: addr=%h req=%b pc4=%h instr=%h v=%b cnt=%0d",
        imem_addr, imem_req, IFID_pc4, IFID_instr, IFID_valid, stall_count);
    end
    @(negedge clk); rst = 1'b0;
    tick;
    n_cmp++;
    if ({imem_req, imem_addr, IFID_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL start: req=%b addr=%h v=%b want 1 0 0",
        imem_req, imem_addr, IFID_valid);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] w [3];
    w[0] = 32'hAAAA_0001; w[1] = 32'hBBBB_0002; w[2] = 32'hCCCC_0003;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = w[i];
      q.push_back('{pc4: 32'(4*(i+1)), instr: w[i], valid: 1'b1});
      tick;
      e = q.pop_front();
      n_cmp++;
      if ({IFID_pc4, IFID_instr, IFID_valid} !== e) begin
        n_err++;
        $display("FAIL fetch%0d: got %h %h %b want %h %h %b", i,
          IFID_pc4, IFID_instr, IFID_valid, e.pc4, e.instr, e.valid);
      end
    end
  endtask

  task automatic test_not_ready;
    imem_ready = 1'b0;
    repeat (2) begin
      q.push_back('{pc4: 32'h0, instr: 32'h0, valid: 1'b0});
      tick;
      e = q.pop_front();
      n_cmp++;
      if ({IFID_pc4, IFID_instr, IFID_valid, imem_addr, imem_req}
          !== {e, 32'd12, 1'b1}) begin
        n_err++;
        $display("FAIL not_ready: got %h %h %b addr=%h req=%b want bubble addr=c req=1",
          IFID_pc4, IFID_instr, IFID_valid, imem_addr, imem_req);
      end
    end
  endtask

  task automatic test_hold;
    imem_ready = 1'b1; imem_rdata = 32'hC2C2_0004;
    q.push_back('{pc4: 32'd16, instr: 32'hC2C2_0004, valid: 1'b1});
    tick;
    e = q.pop_front();
    n_cmp++;
    if ({IFID_pc4, IFID_instr, IFID_valid} !== e) begin
      n_err++;
      $display("FAIL pre_hold: got %h %h %b want %h %h %b",
        IFID_pc4, IFID_instr, IFID_valid, e.pc4, e.instr, e.valid);
    end
    imem_rdata = 32'hDDDD_0005; IFID_write = 1'b0; PCWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      imem_rdata = 32'hDEAD_BEEF;
      n_cmp++;
      if ({IFID_pc4, IFID_instr, IFID_valid, imem_req, imem_addr}
          !== {e, 1'b0, 32'd16}) begin
        n_err++;
        $display("FAIL hold%0d: got %h %h %b req=%b addr=%h", i,
          IFID_pc4, IFID_instr, IFID_valid, imem_req, imem_addr);
      end
    end
    n_cmp++;
    if (stall_count !== 4'd3) begin
      n_err++;
      $display("FAIL hold_cnt: got %0d want 3", stall_count);
    end
    IFID_write = 1'b1; PCWrite = 1'b1; imem_ready = 1'b0;
    q.push_back('{pc4: 32'd20, instr: 32'hDDDD_0005, valid: 1'b1});
    tick;
    e = q.pop_front();
    n_cmp++;
    if ({IFID_pc4, IFID_instr, IFID_valid, imem_addr, imem_req}
        !== {e, 32'd20, 1'b1}) begin
      n_err++;
      $display("FAIL release: got %h %h %b addr=%h req=%b want 14 dddd0005 1 addr=14 req=1",
        IFID_pc4, IFID_instr, IFID_valid, imem_addr, imem_req);
    end
  endtask

  task automatic test_branch;
    imem_ready = 1'b1; imem_rdata = 32'hEEEE_0006;
    IFID_write = 1'b0; PCWrite = 1'b0;
    tick;
    branch_taken = 1'b1; branch_target = 32'h40; imem_rdata = 32'hBAD0_BAD0;
    q.push_back('{pc4: 32'h0, instr: 32'h0, valid: 1'b0});
    tick;
    e = q.pop_front();
    n_cmp++;
    if ({IFID_pc4, IFID_instr, IFID_valid, imem_addr, imem_req}
        !== {e, 32'h40, 1'b1}) begin
      n_err++;
      $display("FAIL branch: got %h %h %b addr=%h req=%b want bubble addr=40 req=1",
        IFID_pc4, IFID_instr, IFID_valid, imem_addr, imem_req);
    end
    branch_taken = 1'b0; IFID_write = 1'b1; PCWrite = 1'b1;
    imem_rdata = 32'hFFFF_0007;
    q.push_back('{pc4: 32'h44, instr: 32'hFFFF_0007, valid: 1'b1});
    tick;
    e = q.pop_front();
    n_cmp++;
    if ({IFID_pc4, IFID_instr, IFID_valid} !== e) begin
      n_err++;
      $display("FAIL post_branch: got %h %h %b want %h %h %b",
        IFID_pc4, IFID_instr, IFID_valid, e.pc4, e.instr, e.valid);
    end
    n_cmp++;
    if (stall_count !== m_stall || stall_count !== 4'd4) begin
      n_err++;
      $display("FAIL branch_cnt: got %0d want 4", stall_count);
    end
  endtask

  task automatic test_wrap;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick;
    branch_taken = 1'b0;
    n_cmp++;
    if ({imem_addr, IFID_valid} !== {32'hFFFF_FFFC, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_pc: addr=%h v=%b want fffffffc 0", imem_addr, IFID_valid);
    end
    imem_rdata = 32'h6666_0008;
    q.push_back('{pc4: 32'h0, instr: 32'h6666_0008, valid: 1'b1});
    tick;
    e = q.pop_front();
    n_cmp++;
    if ({IFID_pc4, IFID_instr, IFID_valid, imem_addr} !== {e, 32'h0}) begin
      n_err++;
      $display("FAIL wrap: got %h %h %b addr=%h want 0 66660008 1 addr=0",
        IFID_pc4, IFID_instr, IFID_valid, imem_addr);
    end
  endtask

  task automatic test_saturate;
    imem_ready = 1'b0; IFID_write = 1'b0; PCWrite = 1'b0;
    repeat (20) tick;
    n_cmp++;
    if (stall_count !== 4'd15 || stall_count !== m_stall) begin
      n_err++;
      $display("FAIL saturate: got %0d want 15", stall_count);
    end
    n_cmp++;
    if ({IFID_pc4, IFID_instr, IFID_valid} !== {32'h0, 32'h6666_0008, 1'b1}) begin
      n_err++;
      $display("FAIL sat_frozen: got %h %h %b", IFID_pc4, IFID_instr, IFID_valid);
    end
  endtask

  task automatic test_async_reset;
    imem_ready = 1'b1; imem_rdata = 32'h7777_0009;
    tick;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL in_hold: req=%b want 0", imem_req);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({imem_addr, imem_req, IFID_pc4, IFID_instr, IFID_valid, stall_count}
        !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0}) begin
      n_err++;
      $display("FAIL async_rst: addr=%h req=%b pc4=%h instr=%h v=%b cnt=%0d",
        imem_addr, imem_req, IFID_pc4, IFID_instr, IFID_valid, stall_count);
    end
    @(negedge clk); rst = 1'b0; IFID_write = 1'b1; PCWrite = 1'b1;
    tick;
    n_cmp++;
    if ({imem_req, imem_addr, IFID_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL restart: req=%b addr=%h v=%b want 1 0 0",
        imem_req, imem_addr, IFID_valid);
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_not_ready;
    test_hold;
    test_branch;
    test_wrap;
    test_saturate;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
